// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues synchronous ROM reads and buffers
// the returned instructions (tagged with their PC) in a small FIFO for the decode stage.
module instr_fetch_queue #(
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned INSTR_W = 49,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ROM_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               rom_en,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [INSTR_W-1:0] rom_data,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  fetch_pc
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W   = CNT_W + 2;
   localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wptr_q, wptr_d;
   logic [PTR_W-1:0]   rptr_q, rptr_d;
   logic [ROM_LAT-1:0] infl_q, infl_d;
   logic [ADDR_W-1:0]  tag_q [ROM_LAT];
   logic [ADDR_W-1:0]  tag_d [ROM_LAT];
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];

   logic [SUM_W-1:0]   inflight;
   logic               push;
   logic               pop;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < ROM_LAT; i++) begin
         inflight = inflight + SUM_W'(infl_q[i]);
      end
   end

   // Reads already in flight reserve FIFO space, so a returning word can always be stored.
   assign rom_en    = !redirect && ((SUM_W'(count_q) + inflight) < SUM_W'(DEPTH));
   assign rom_addr  = fetch_pc_q;
   assign fetch_pc  = fetch_pc_q;

   assign out_valid = (count_q != '0);
   assign {out_instr, out_pc} = mem_q[rptr_q];

   assign push = infl_q[ROM_LAT-1];
   assign pop  = out_valid && out_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      mem_d      = mem_q;
      infl_d[0]  = rom_en;
      tag_d[0]   = fetch_pc_q;
      for (int i = 1; i < ROM_LAT; i++) begin
         infl_d[i] = infl_q[i-1];
         tag_d[i]  = tag_q[i-1];
      end

      if (redirect) begin
         // Redirect wins over everything: drop queued, returning and same-edge popped entries.
         fetch_pc_d = redirect_pc;
         count_d    = '0;
         wptr_d     = '0;
         rptr_d     = '0;
         infl_d     = '0;
      end else begin
         if (rom_en) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
         end
         if (push) begin
            mem_d[wptr_q] = {rom_data, tag_q[ROM_LAT-1]};
            wptr_d        = wptr_q + PTR_W'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= '0;
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         infl_q     <= '0;
         for (int i = 0; i < ROM_LAT; i++) begin
            tag_q[i] <= '0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         infl_q     <= infl_d;
         tag_q      <= tag_d;
         mem_q      <= mem_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic, with a scoreboard that
// expects consecutive PCs from the last reset/redirect target and their ROM contents.
module tb_instr_fetch_queue;

   localparam int unsigned ADDR_W  = 6;
   localparam int unsigned INSTR_W = 49;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned ROM_LAT = 1;
   localparam int unsigned ROM_N   = 1 << ADDR_W;

   logic               clk;
   logic               rst;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               rom_en;
   logic [ADDR_W-1:0]  rom_addr;
   logic [INSTR_W-1:0] rom_data;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic               out_ready;
   logic [ADDR_W-1:0]  fetch_pc;

   instr_fetch_queue #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .DEPTH   (DEPTH),
      .ROM_LAT (ROM_LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .rom_en      (rom_en),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_ready   (out_ready),
      .fetch_pc    (fetch_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM with ROM_LAT edges of read latency.
   logic [INSTR_W-1:0] rom_mem [ROM_N];
   logic [ADDR_W-1:0]  rd_addr_q [ROM_LAT];

   always @(posedge clk) begin
      rd_addr_q[0] <= rom_addr;
      for (int i = 1; i < ROM_LAT; i++) begin
         rd_addr_q[i] <= rd_addr_q[i-1];
      end
   end
   assign rom_data = rom_mem[rd_addr_q[ROM_LAT-1]];

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } exp_t;

   exp_t              exp_q [$];
   logic [ADDR_W-1:0] next_pc;
   int                checks = 0;
   int                errors = 0;
   int                pops   = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void sb_fill();
      exp_t e;
      while (exp_q.size() < 8) begin
         e.pc    = next_pc;
         e.instr = rom_mem[next_pc];
         exp_q.push_back(e);
         next_pc = next_pc + ADDR_W'(1);
      end
   endfunction

   // After reset or redirect the decode stream must be consecutive PCs from the new start.
   function automatic void sb_restart(input logic [ADDR_W-1:0] pc);
      exp_q.delete();
      next_pc = pc;
      sb_fill();
   endfunction

   // Monitor: inputs change just after posedge, so the negedge sees what the next edge acts on.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            sb_restart('0);
         end else if (redirect) begin
            sb_restart(redirect_pc);
         end else if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            chk("sb_pc", 64'(out_pc), 64'(e.pc));
            chk("sb_instr", 64'(out_instr), 64'(e.instr));
            pops++;
            sb_fill();
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst      = 1'b0;
      redirect = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      int p0;
      for (int i = 0; i < ROM_N; i++) begin
         rom_mem[i] = {17'($urandom), 32'(i + 100)};
      end
      rst         = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = 1'b1;

      // Reset values and streaming.
      tick();
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_fetch_pc", 64'(fetch_pc), 64'(0));
      chk("rst_out_pc", 64'(out_pc), 64'(0));
      chk("rst_out_instr", 64'(out_instr), 64'(0));
      tick();
      rst = 1'b1;
      tick();
      chk("stream_first_valid", 64'(out_valid), 64'(0));
      chk("stream_first_issue", 64'(fetch_pc), 64'(1));
      tick();
      chk("stream_valid0", 64'(out_valid), 64'(1));
      chk("stream_pc0", 64'(out_pc), 64'(0));
      chk("stream_instr0", 64'(out_instr), 64'(rom_mem[0]));
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("stream_no_gap", 64'(out_valid), 64'(1));
      end

      // Back-pressure: queue fills, fetch stalls, then drains without gaps.
      out_ready = 1'b0;
      reset_dut();
      repeat (10) tick();
      chk("bp_rom_en", 64'(rom_en), 64'(0));
      chk("bp_fetch_pc", 64'(fetch_pc), 64'(DEPTH));
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_head_pc", 64'(out_pc), 64'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("bp_drain_valid", 64'(out_valid), 64'(1));
      end

      // Redirect with two entries queued and one in flight.
      out_ready = 1'b0;
      reset_dut();
      repeat (3) tick();
      chk("redir_pre_valid", 64'(out_valid), 64'(1));
      redirect    = 1'b1;
      redirect_pc = ADDR_W'(40);
      #1;
      chk("redir_rom_en", 64'(rom_en), 64'(0));
      tick();
      redirect  = 1'b0;
      out_ready = 1'b1;
      chk("redir_valid_r0", 64'(out_valid), 64'(0));
      chk("redir_fetch_pc", 64'(fetch_pc), 64'(40));
      tick();
      chk("redir_valid_r1", 64'(out_valid), 64'(0));
      tick();
      chk("redir_valid_r2", 64'(out_valid), 64'(1));
      chk("redir_pc_r2", 64'(out_pc), 64'(40));
      tick();
      chk("redir_pc_r3", 64'(out_pc), 64'(41));

      // PC wrap: 62, 63, 0, 1.
      repeat (3) tick();
      redirect    = 1'b1;
      redirect_pc = ADDR_W'(62);
      tick();
      redirect = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wrap_valid", 64'(out_valid), 64'(1));
         chk("wrap_pc", 64'(out_pc), 64'((62 + i) % 64));
      end

      // Redirect, pop and ROM return on the same edge.
      chk("simul_pre_valid", 64'(out_valid), 64'(1));
      redirect    = 1'b1;
      redirect_pc = ADDR_W'(20);
      tick();
      redirect = 1'b0;
      chk("simul_valid", 64'(out_valid), 64'(0));
      chk("simul_fetch_pc", 64'(fetch_pc), 64'(20));
      tick();
      chk("simul_dropped", 64'(out_valid), 64'(0));
      tick();
      chk("simul_target_pc", 64'(out_pc), 64'(20));

      // Asynchronous reset between edges with three entries queued.
      out_ready = 1'b0;
      reset_dut();
      repeat (4) tick();
      chk("async_pre_valid", 64'(out_valid), 64'(1));
      #1;
      rst = 1'b0;
      #1;
      chk("async_valid", 64'(out_valid), 64'(0));
      chk("async_fetch_pc", 64'(fetch_pc), 64'(0));
      chk("async_out_pc", 64'(out_pc), 64'(0));
      tick();
      rst       = 1'b1;
      out_ready = 1'b1;
      repeat (2) tick();
      chk("async_restart_valid", 64'(out_valid), 64'(1));
      chk("async_restart_pc", 64'(out_pc), 64'(0));

      // Random traffic against the scoreboard.
      p0 = pops;
      for (int i = 0; i < 3000; i++) begin
         tick();
         out_ready   = ($urandom_range(99) < 70);
         redirect    = ($urandom_range(99) < 4);
         redirect_pc = ADDR_W'($urandom);
         rst         = !($urandom_range(999) < 3);
      end
      rst      = 1'b1;
      redirect = 1'b0;
      repeat (4) tick();
      chk("random_progress", 64'(pops - p0 >= 300), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
